y86_instr_encoder: RTL
======================

Y86_INSTR_ENCODER -- requirements
Module: y86_instr_encoder

Interface
REQ-001 The block SHALL operate on one clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- addr_load  in  1  load write pointer
- load_addr  in  64  new write-pointer value
- in_valid  in  1  instruction fields present
- in_ready  out  1  block can accept an instruction
- icode  in  4  instruction code
- ifun  in  4  function code
- rA  in  4  register A
- rB  in  4  register B
- valC  in  64  constant or destination
- mem_we  out  1  byte write strobe to instruction memory
- mem_addr  out  64  byte address
- mem_wdata  out  8  byte data
- err_pulse  out  1  one-cycle invalid-icode flag
- err_sticky  out  1  invalid icode seen since reset or addr_load
- next_pc  out  64  current write pointer
- instr_count  out  32  instructions successfully emitted

Function
REQ-003 The FSM SHALL have states IDLE and EMIT; in_ready SHALL be 1 only in IDLE.
REQ-004 Accept SHALL occur on in_valid && in_ready; the block SHALL latch all fields and the length, then enter EMIT on the next cycle.
REQ-005 Lengths SHALL be: icode 0,1,9 -> 1 byte; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10.
REQ-006 Byte 0 SHALL be {icode,ifun}.
REQ-007 For 2- and 10-byte formats, byte 1 SHALL be {rA,rB} (rA in upper nibble); irmovq (3) SHALL force rA=F; pushq/popq (A,B) SHALL force rB=F.
REQ-008 valC SHALL be emitted little-endian: bytes 2..9 for 10-byte formats, bytes 1..8 for 9-byte formats; byte i of valC = valC[8i+7:8i].
REQ-009 In EMIT the block SHALL write exactly one byte per cycle: mem_we=1, mem_addr=next_pc+k, k=0..len-1.
REQ-010 next_pc SHALL advance by len in the cycle the last byte is written; the block SHALL return to IDLE the following cycle; instr_count SHALL increment by 1 at the same time.
REQ-011 Latency: accept in cycle N -> byte 0 in N+1, last byte in N+len, in_ready high again in N+len+1.
REQ-012 icode > B SHALL be accepted, SHALL raise err_pulse for exactly the cycle after accept, SHALL set err_sticky, SHALL write no bytes, and SHALL leave next_pc and instr_count unchanged; the FSM SHALL stay in IDLE.
REQ-013 addr_load in IDLE SHALL set next_pc=load_addr and clear err_sticky; in EMIT it SHALL be ignored.
REQ-014 addr_load and accept in the same IDLE cycle: the load SHALL take effect first, so the instruction is written starting at load_addr.
REQ-015 Address arithmetic SHALL wrap modulo 2^64 (bytes of one instruction may straddle FFFF_FFFF_FFFF_FFFF -> 0); instr_count SHALL wrap modulo 2^32.
REQ-016 mem_addr and mem_wdata SHALL be 0 whenever mem_we=0.

Reset
REQ-017 On reset: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, err_pulse=0, err_sticky=0, next_pc=0, instr_count=0.
REQ-018 Reset mid-EMIT SHALL abort the instruction immediately; partially written bytes are not retracted; the byte counter SHALL clear.

Structure
REQ-019 A shared package SHALL hold icode constants (HALT..POPQ), RNONE=4'hF, and the FSM state type.
REQ-020 A combinational sub-module y86_instr_len SHALL map icode to {len, has_regbyte, has_valC, valid}; Fetch SHALL reuse it.

Verification
REQ-021 Reset, next_pc=0, send halt (icode 0, ifun 0) -> one write addr 0 data 00; next_pc=1; instr_count=1.
REQ-022 Send irmovq rB=2 valC=0x0000_0000_0000_0102 with rA=3 -> bytes 30 F2 02 01 00 00 00 00 00 00 at addr 0..9; in_ready low 10 cycles; next_pc=10.
REQ-023 addr_load load_addr=0x30 with simultaneous jXX ifun 0 valC=0x40 -> 70 40 00 00 00 00 00 00 00 at 0x30..0x38; next_pc=0x39.
REQ-024 Send icode C -> err_pulse for one cycle, err_sticky=1, no mem_we, next_pc unchanged; later addr_load clears err_sticky.
REQ-025 load_addr=0xFFFF_FFFF_FFFF_FFFF, send pushq rA=4 rB=7 -> A0 at FFFF_FFFF_FFFF_FFFF, 4F at 0; next_pc=1.
REQ-026 Assert reset after byte 3 of an rmmovq -> mem_we=0 next cycle, all outputs at reset values, in_ready=1.

Source files
------------

// File: rtl/y86_instr_encoder_pkg.sv
// Shared definitions for the Y86-64 instruction encoder and fetch path.
//   - icode constants HALT..POPQ, RNONE register id
//   - FSM state type
//   - len_info_t: decoded length / format information for one icode
package y86_instr_encoder_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  typedef struct packed {
    logic [3:0] len;          // total bytes, 1..10
    logic       has_regbyte;  // byte 1 is {rA,rB}
    logic       has_valc;     // 8-byte little-endian constant follows
    logic       valid;        // icode is a defined instruction
  } len_info_t;

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode -> instruction format decoder. Shared with Fetch.
//   icode : instruction code
//   info  : {len, has_regbyte, has_valc, valid}; all zero for undefined icodes
module y86_instr_len
  import y86_instr_encoder_pkg::*;
(
  input  logic [3:0] icode,
  output len_info_t  info
);

  always_comb begin
    info = '0;
    case (icode)
      I_HALT, I_NOP, I_RET:
        info = '{len: 4'd1,  has_regbyte: 1'b0, has_valc: 1'b0, valid: 1'b1};
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:
        info = '{len: 4'd2,  has_regbyte: 1'b1, has_valc: 1'b0, valid: 1'b1};
      I_JXX, I_CALL:
        info = '{len: 4'd9,  has_regbyte: 1'b0, has_valc: 1'b1, valid: 1'b1};
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:
        info = '{len: 4'd10, has_regbyte: 1'b1, has_valc: 1'b1, valid: 1'b1};
      default: info = '0;
    endcase
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction encoder: accepts one instruction's fields, then streams
// its encoding to instruction memory one byte per cycle at next_pc, next_pc+1..
//   clk, reset          : clock, synchronous active-high reset
//   addr_load/load_addr : reposition the write pointer (IDLE only)
//   in_valid/in_ready   : instruction handshake; fields icode/ifun/rA/rB/valC
//   mem_we/addr/wdata   : byte write port (addr/data zero when not writing)
//   err_pulse/err_sticky: undefined-icode flags
//   next_pc             : current write pointer
//   instr_count         : instructions fully emitted (wraps mod 2^32)
module y86_instr_encoder
  import y86_instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        addr_load,
  input  logic [63:0] load_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        err_pulse,
  output logic        err_sticky,
  output logic [63:0] next_pc,
  output logic [31:0] instr_count
);

  state_t      state;
  len_info_t   info;
  logic [3:0]  cnt;       // bytes already placed on the write port
  logic [3:0]  len_q;
  logic        has_reg_q;
  logic [7:0]  regb_q;
  logic [63:0] valc_q;

  logic        accept;
  logic [63:0] base;
  logic [7:0]  regb_in;
  logic [7:0]  cur_byte;
  logic [2:0]  vidx;

  y86_instr_len u_len (.icode(icode), .info(info));

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  // A simultaneous load wins, so the instruction lands at load_addr.
  assign base     = addr_load ? load_addr : next_pc;
  assign regb_in  = {(icode == I_IRMOVQ) ? RNONE : rA,
                     (icode == I_PUSHQ || icode == I_POPQ) ? RNONE : rB};

  // Byte index cnt of the latched instruction (cnt >= 1 while in EMIT;
  // byte 0 is driven straight from the inputs at accept).
  always_comb begin
    vidx = has_reg_q ? 3'(cnt - 4'd2) : 3'(cnt - 4'd1);
    if (has_reg_q && cnt == 4'd1) cur_byte = regb_q;
    else                          cur_byte = valc_q[8*vidx +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      len_q       <= '0;
      has_reg_q   <= 1'b0;
      regb_q      <= '0;
      valc_q      <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
      next_pc     <= '0;
      instr_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (addr_load) begin
            next_pc    <= load_addr;
            err_sticky <= 1'b0;
          end
          if (accept) begin
            if (info.valid) begin
              len_q     <= info.len;
              has_reg_q <= info.has_regbyte;
              regb_q    <= regb_in;
              valc_q    <= valC;
              mem_we    <= 1'b1;
              mem_addr  <= base;
              mem_wdata <= {icode, ifun};
              cnt       <= 4'd1;
              state     <= S_EMIT;
            end else begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (cnt == len_q) begin
            // Last byte is on the port this cycle: commit and release.
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            next_pc     <= next_pc + 64'(len_q);
            instr_count <= instr_count + 32'd1;
            cnt         <= '0;
            state       <= S_IDLE;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= next_pc + 64'(cnt);
            mem_wdata <= cur_byte;
            cnt       <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
